// File: rtl/dilithium_pkg.sv
// -----------------------------------------------------------------------------
// dilithium_pkg
// Shared ML-DSA constants, coefficient types and small arithmetic helpers used
// by the z = y + cs1 compute/check slice.
//   Q          : modulus
//   N, L       : coefficients per polynomial, polynomials per vector
//   GAMMA1_VAL : 1 << GAMMA1
//   Z_BOUND    : GAMMA1_VAL - BETA, infinity-norm rejection bound
//   coeff_t    : stored signed coefficient (24 bits)
//   wide_t     : one extra bit, used for the exact sum before truncation
// -----------------------------------------------------------------------------
package dilithium_pkg;

    localparam int L          = 7;
    localparam int N          = 256;
    localparam int GAMMA1     = 19;
    localparam int BETA       = 120;
    localparam int Q          = 8380417;
    localparam int COEFF_W    = 24;
    localparam int NL         = N * L;
    localparam int ADDR_W     = $clog2(NL);
    localparam int GAMMA1_VAL = 1 << GAMMA1;
    localparam int Z_BOUND    = GAMMA1_VAL - BETA;
    localparam int WIDE_W     = COEFF_W + 1;

    typedef logic signed [COEFF_W-1:0] coeff_t;
    typedef logic signed [WIDE_W-1:0]  wide_t;
    typedef logic        [ADDR_W-1:0]  addr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam addr_t               LAST_ADDR = addr_t'(NL - 1);
    localparam wide_t               Z_BOUND_W = wide_t'(Z_BOUND);
    localparam wide_t               Q_W       = wide_t'(Q);
    localparam logic [COEFF_W-1:0]  HALF_Q    = COEFF_W'((Q - 1) / 2);

    // Map a residue in [0,Q) to the centered range (-Q/2, Q/2].
    function automatic wide_t center_q(input logic [COEFF_W-1:0] r);
        wide_t rw;
        rw = $signed({1'b0, r});
        return (r > HALF_Q) ? (rw - Q_W) : rw;
    endfunction

    // |v| >= Z_BOUND on the untruncated sum.
    function automatic logic exceeds_bound(input wide_t v);
        return (v >= Z_BOUND_W) || (v <= -Z_BOUND_W);
    endfunction

endpackage

// File: rtl/z_compute_check_if.sv
// -----------------------------------------------------------------------------
// z_compute_check_if
// BRAM-side bus of z_compute_check: two read ports (y, cs1) with 1-cycle
// registered-read latency and one write port (z).
//   master : the compute block (drives addresses and the z write)
//   slave  : the memories (return dout_y / dout_cs1)
// There is no valid/ready handshake: a read address presented before a clock
// edge returns its data after that edge; a write happens on every edge where
// we_z is high.
// -----------------------------------------------------------------------------
interface z_compute_check_if;
    import dilithium_pkg::*;

    addr_t              addr_y;
    coeff_t             dout_y;
    addr_t              addr_cs1;
    logic [COEFF_W-1:0] dout_cs1;
    logic               we_z;
    addr_t              addr_z;
    coeff_t             din_z;

    modport master (
        output addr_y, addr_cs1, we_z, addr_z, din_z,
        input  dout_y, dout_cs1
    );

    modport slave (
        input  addr_y, addr_cs1, we_z, addr_z, din_z,
        output dout_y, dout_cs1
    );

endinterface

// File: rtl/z_compute_check_coeff.sv
// -----------------------------------------------------------------------------
// z_coeff_unit
// Two-stage registered pipe for one coefficient per cycle.
//   Stage A: sum = sext(y) + centered(cs1), kept at 25 bits.
//   Stage B: z = sum truncated to 24 bits, norm-violation flag, write address.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               kill both stages' valid bits on this edge
//   in_valid, in_addr   BRAM data valid this cycle, and the address it came from
//   in_y, in_cs1        BRAM read data
//   mid_valid           stage A holds a coefficient (used for drain detection)
//   out_valid           stage B holds a coefficient (drives the z write)
//   out_addr, out_z     z write address / data
//   out_viol            |sum| >= Z_BOUND for the coefficient in stage B
// -----------------------------------------------------------------------------
module z_coeff_unit
    import dilithium_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    input  addr_t              in_addr,
    input  coeff_t             in_y,
    input  logic [COEFF_W-1:0] in_cs1,
    output logic               mid_valid,
    output logic               out_valid,
    output addr_t              out_addr,
    output coeff_t             out_z,
    output logic               out_viol
);

    wide_t a_sum;
    addr_t a_addr;
    wide_t sum_next;

    assign sum_next = $signed({in_y[COEFF_W-1], in_y}) + center_q(in_cs1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_valid <= 1'b0;
            a_sum     <= '0;
            a_addr    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_z     <= '0;
            out_viol  <= 1'b0;
        end else begin
            mid_valid <= in_valid & ~flush;
            out_valid <= mid_valid & ~flush;
            if (in_valid) begin
                a_sum  <= sum_next;
                a_addr <= in_addr;
            end
            if (mid_valid) begin
                // The bound is checked on the 25-bit sum, before truncation.
                out_z    <= $signed(a_sum[COEFF_W-1:0]);
                out_viol <= exceeds_bound(a_sum);
                out_addr <= a_addr;
            end
        end
    end

endmodule

// File: rtl/z_compute_check.sv
// -----------------------------------------------------------------------------
// z_compute_check
// Streams y[i] and cs1[i] out of two BRAMs, writes z = y + centered(cs1) to
// the z BRAM and checks ||z||_inf < GAMMA1_VAL - BETA over all N*L
// coefficients.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        begin a pass; only honoured in IDLE or DONE
//   done         level, high in DONE until the next accepted start
//   reject       sticky norm violation of the current pass, valid with done
//   bram         z_compute_check_if.master (y/cs1 reads, z write)
//   dbg_state    current FSM state
// Build option:
//   Z_EARLY_ABORT_EN  when defined, the first violating write ends the pass
//                     (data-dependent latency). Undefined: every coefficient
//                     is always processed, so latency is constant.
// Timing with start sampled at edge t: address k is driven after edge t+k
// (sampled by the BRAM at t+1+k), z[k] is written after edge t+3+k, and done
// rises at edge t+N*L+3.
// -----------------------------------------------------------------------------
module z_compute_check
    import dilithium_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                done,
    output logic                reject,
    z_compute_check_if.master   bram,
    output state_t              dbg_state
);

    state_t state;
    addr_t  addr_q;
    addr_t  rd_addr;
    logic   issue_v;
    logic   rd_v;
    logic   abort;

    logic   mid_v;
    logic   out_v;
    logic   out_viol;
    addr_t  out_addr;
    coeff_t out_z;

`ifdef Z_EARLY_ABORT_EN
    assign abort = out_v & out_viol;
`else
    assign abort = 1'b0;
`endif

    z_coeff_unit u_coeff (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .in_valid  (rd_v),
        .in_addr   (rd_addr),
        .in_y      (bram.dout_y),
        .in_cs1    (bram.dout_cs1),
        .mid_valid (mid_v),
        .out_valid (out_v),
        .out_addr  (out_addr),
        .out_z     (out_z),
        .out_viol  (out_viol)
    );

    assign bram.addr_y   = addr_q;
    assign bram.addr_cs1 = addr_q;
    assign bram.we_z     = out_v;
    assign bram.addr_z   = out_addr;
    assign bram.din_z    = out_z;
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            rd_addr <= '0;
            issue_v <= 1'b0;
            rd_v    <= 1'b0;
            done    <= 1'b0;
            reject  <= 1'b0;
        end else begin
            // rd_v marks BRAM data for the address driven in the previous cycle.
            rd_v <= issue_v & ~abort;
            if (issue_v) begin
                rd_addr <= addr_q;
            end
            if (out_v && out_viol) begin
                reject <= 1'b1;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        addr_q  <= '0;
                        issue_v <= 1'b1;
                        done    <= 1'b0;
                        reject  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state   <= ST_DONE;
                        issue_v <= 1'b0;
                        done    <= 1'b1;
                    end else if (addr_q == LAST_ADDR) begin
                        state   <= ST_DRAIN;
                        issue_v <= 1'b0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The last write is leaving stage B on this edge when
                    // neither earlier stage holds data.
                    if (abort || (!rd_v && !mid_v)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z_compute_check.sv
// -----------------------------------------------------------------------------
// tb_z_compute_check
// Bench for z_compute_check: BRAM models for y/cs1, a reference model that
// derives every expected z write (cycle, address, data), the done cycle and
// the reject flag from the arithmetic rules, and a monitor that pops the
// expected-write queue on every we_z.
// -----------------------------------------------------------------------------
module tb_z_compute_check;
    import dilithium_pkg::*;

    localparam int TQ     = 8380417;
    localparam int TNL    = 256 * 7;
    localparam int TBOUND = (1 << 19) - 120;
    localparam int EW     = 32 + 11 + 24;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    logic   start = 1'b0;
    logic   done;
    logic   reject;
    state_t dbg_state;

    z_compute_check_if bram ();

    z_compute_check dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .done      (done),
        .reject    (reject),
        .bram      (bram),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- BRAM models (1-cycle registered read) ----------------
    logic [23:0] mem_y   [TNL];
    logic [23:0] mem_cs1 [TNL];

    always @(posedge clk) begin
        bram.dout_y   <= mem_y[bram.addr_y];
        bram.dout_cs1 <= mem_cs1[bram.addr_cs1];
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bram.we_z) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0h at cycle %0d, no write expected",
                         bram.addr_z, bram.din_z, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("z_write{cycle,addr,z}", {32'(cyc), bram.addr_z, bram.din_z}, mon_e);
            end
        end
    end

    // ---------------- reference model ----------------
    // Walks the memories in address order with plain integer arithmetic.
    task automatic build_expect(input int t, output int done_at, output logic rej);
        int          yi;
        int          ci;
        int          z;
        logic [23:0] z24;
        rej     = 1'b0;
        done_at = t + TNL + 3;
        for (int k = 0; k < TNL; k++) begin
            yi = int'(mem_y[k]);
            if (yi >= (1 << 23)) yi -= (1 << 24);
            ci = int'(mem_cs1[k]);
            if (ci > (TQ - 1) / 2) ci -= TQ;
            z   = yi + ci;
            z24 = z[23:0];
            exp_q.push_back({32'(t + 3 + k), 11'(k), z24});
            if (z >= TBOUND || z <= -TBOUND) begin
                rej = 1'b1;
`ifdef Z_EARLY_ABORT_EN
                done_at = t + k + 4;
                break;
`endif
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        for (int k = 0; k < TNL; k++) begin
            mem_y[k]   = '0;
            mem_cs1[k] = '0;
        end
    endtask

    task automatic fill_small_random();
        int d;
        for (int k = 0; k < TNL; k++) begin
            mem_y[k] = 24'(int'($urandom_range(524288, 0)) - 262144);
            d        = int'($urandom_range(2000, 0)) - 1000;
            mem_cs1[k] = 24'((d < 0) ? d + TQ : d);
        end
    endtask

    task automatic fill_full_random();
        for (int k = 0; k < TNL; k++) begin
            mem_y[k]   = 24'(int'($urandom_range(1048575, 0)) - 524287);
            mem_cs1[k] = 24'($urandom_range(TQ - 1, 0));
        end
    endtask

    // One pass: start, optionally re-pulse start mid-run, wait for done.
    task automatic run_pass(input string name, input bit mid_pulse);
        int   t;
        int   done_at;
        int   i;
        logic rej_exp;
        @(negedge clk);
        start = 1'b1;
        t     = cyc + 1;
        build_expect(t, done_at, rej_exp);
        @(negedge clk);
        start = 1'b0;
        i = 0;
        while (i < 2600 && !done) begin
            start = mid_pulse && (i == 100);
            @(negedge clk);
            i++;
        end
        start = 1'b0;
        check({name, "_done_seen"}, done, 1'b1);
        if (done) begin
            check({name, "_done_cycle"}, cyc - t, done_at - t);
            check({name, "_reject"}, reject, rej_exp);
            check({name, "_writes_missing"}, exp_q.size(), 0);
        end
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        int d_at;
        logic r_exp;

        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_done", done, 1'b0);
        check("rst_reject", reject, 1'b0);
        check("rst_we_z", bram.we_z, 1'b0);
        check("rst_addr_y", bram.addr_y, 0);
        check("rst_addr_cs1", bram.addr_cs1, 0);
        check("rst_addr_z", bram.addr_z, 0);
        check("rst_din_z", bram.din_z, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All zero, with a start pulse in the middle of RUN.
        run_pass("zeros", 1'b1);

        // Near-bound legal values, including y = +GAMMA1_VAL and cs1 = Q-1.
        fill_small_random();
        mem_y[5] = 24'h07FF00;       mem_cs1[5] = 24'(TQ - 1);
        mem_y[6] = 24'(1 << 19);     mem_cs1[6] = 24'(TQ - 200);
        mem_y[7] = 24'h000000;       mem_cs1[7] = 24'h000000;
        run_pass("legal_edge", 1'b0);

        // z exactly at the bound rejects.
        clear_mem();
        mem_y[5] = 24'(TBOUND);
        run_pass("at_bound", 1'b0);

        // Back-to-back start from DONE: reject must be recomputed.
        clear_mem();
        run_pass("recompute", 1'b0);

        // Negative violation at index 10.
        clear_mem();
        mem_y[10] = 24'hF80001;      mem_cs1[10] = 24'(TQ - 200);
        run_pass("neg_viol", 1'b0);

        // Centering boundary: (Q-1)/2 stays positive, (Q+1)/2 wraps negative.
        clear_mem();
        mem_cs1[3] = 24'((TQ - 1) / 2);
        run_pass("half_pos", 1'b0);
        clear_mem();
        mem_cs1[3] = 24'((TQ + 1) / 2);
        run_pass("half_neg", 1'b0);

        // Full-range random data.
        fill_full_random();
        run_pass("rand_full", 1'b0);
        fill_small_random();
        run_pass("rand_small", 1'b0);

        // Asynchronous reset 500 cycles into a pass.
        clear_mem();
        mem_y[1000] = 24'(TBOUND);
        @(negedge clk);
        start = 1'b1;
        t     = cyc + 1;
        build_expect(t, d_at, r_exp);
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_done", done, 1'b0);
        check("midrst_reject", reject, 1'b0);
        check("midrst_we_z", bram.we_z, 1'b0);
        check("midrst_addr_y", bram.addr_y, 0);
        check("midrst_addr_z", bram.addr_z, 0);
        check("midrst_din_z", bram.din_z, 0);
        check("midrst_state", dbg_state, ST_IDLE);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("postrst_state", dbg_state, ST_IDLE);
        check("postrst_done", done, 1'b0);
        clear_mem();
        run_pass("after_reset", 1'b0);

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
